// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline-register controller: FSM encoding, default sizes, stage control pair.
// No logic of its own; imported by pipe_hazard_ctrl and pipe_load_use_detect.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_e;

   localparam int REG_AW_DFLT       = 5;
   localparam int DRAIN_CYCLES_DFLT = 3;

   typedef struct packed {
      logic en;
      logic clr;
   } stage_ctl_t;

   localparam stage_ctl_t CTL_HOLD      = '{en: 1'b0, clr: 1'b0};
   localparam stage_ctl_t CTL_LOAD      = '{en: 1'b1, clr: 1'b0};
   localparam stage_ctl_t CTL_CLR       = '{en: 1'b0, clr: 1'b1};
   localparam stage_ctl_t CTL_LOAD_CLR  = '{en: 1'b1, clr: 1'b1};

endpackage

// File: rtl/pipe_load_use_detect.sv
// Load-use hazard detect: ID reads a register that the load in EX has yet to produce.
// Purely combinational, zero latency; no flow control.
module pipe_load_use_detect
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW = REG_AW_DFLT
) (
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rt,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_memread,
   output logic              load_use
);

   // Register 0 is hardwired, so a load targeting it never creates a dependency.
   assign load_use = ex_memread && (ex_rd != '0) &&
                     ((ex_rd == id_rs) || (id_use_rt && (ex_rd == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline-register controller (stall/flush/freeze/drain-halt); outputs combinational, act on the same edge.
// mem_busy freezes every stage; optional perf counters built only under PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW       = REG_AW_DFLT,
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DFLT,
   parameter int CNT_W        = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rt,
   input  logic              id_halt,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_memread,
   input  logic              ex_branch_taken,
   input  logic              mem_busy,
   input  logic              go,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              ifid_clr,
   output logic              idex_en,
   output logic              idex_clr,
   output logic              exmem_en,
   output logic              exmem_clr,
   output logic              memwb_en,
   output logic              memwb_clr,
   output logic              halted,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

   state_e     state_q, state_d;
   logic [3:0] drain_q, drain_d;
   logic       load_use;
   stage_ctl_t ifid_c, idex_c, exmem_c, memwb_c;

   pipe_load_use_detect #(.REG_AW(REG_AW)) u_lu (
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_use_rt  (id_use_rt),
      .ex_rd      (ex_rd),
      .ex_memread (ex_memread),
      .load_use   (load_use)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      pc_en   = 1'b0;
      ifid_c  = CTL_HOLD;
      idex_c  = CTL_HOLD;
      exmem_c = CTL_HOLD;
      memwb_c = CTL_HOLD;
      if (rst) begin
         ifid_c  = CTL_CLR;
         idex_c  = CTL_CLR;
         exmem_c = CTL_CLR;
         memwb_c = CTL_CLR;
      end else begin
         case (state_q)
            RUN: begin
               if (!mem_busy) begin
                  pc_en   = 1'b1;
                  ifid_c  = CTL_LOAD;
                  idex_c  = CTL_LOAD;
                  exmem_c = CTL_LOAD;
                  memwb_c = CTL_LOAD;
                  // Branch wins over load-use: the ID instruction is squashed anyway.
                  if (ex_branch_taken) begin
                     ifid_c = CTL_LOAD_CLR;
                     idex_c = CTL_LOAD_CLR;
                  end else if (load_use) begin
                     pc_en  = 1'b0;
                     ifid_c = CTL_HOLD;
                     idex_c = CTL_LOAD_CLR;
                  end
                  if (id_halt && !ex_branch_taken) begin
                     state_d = DRAIN;
                     drain_d = '0;
                  end
               end
            end
            DRAIN: begin
               if (!mem_busy) begin
                  ifid_c  = CTL_CLR;
                  idex_c  = CTL_LOAD;
                  exmem_c = CTL_LOAD;
                  memwb_c = CTL_LOAD;
                  if (drain_q == DRAIN_LAST) begin
                     state_d = HALTED;
                  end else begin
                     drain_d = drain_q + 4'd1;
                  end
               end
            end
            HALTED: begin
               if (go) state_d = RUN;
            end
            default: state_d = RUN;
         endcase
      end
   end

   assign ifid_en   = ifid_c.en;
   assign ifid_clr  = ifid_c.clr;
   assign idex_en   = idex_c.en;
   assign idex_clr  = idex_c.clr;
   assign exmem_en  = exmem_c.en;
   assign exmem_clr = exmem_c.clr;
   assign memwb_en  = memwb_c.en;
   assign memwb_clr = memwb_c.clr;
   assign halted    = (state_q == HALTED) && !rst;

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
   logic             run_live;

   assign run_live = (state_q == RUN) && !mem_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else if (run_live && ex_branch_taken) begin
         flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end else if (run_live && load_use) begin
         stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations, then random traffic vs a rule model.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   localparam int DRAIN_N = 3;

   localparam logic [8:0] V_RESET  = 9'b001010101;
   localparam logic [8:0] V_NORMAL = 9'b110101010;
   localparam logic [8:0] V_BRANCH = 9'b111111010;
   localparam logic [8:0] V_STALL  = 9'b000111010;
   localparam logic [8:0] V_DRAIN  = 9'b001101010;
   localparam logic [8:0] V_FROZEN = 9'b000000000;

   logic       clk;
   logic       rst;
   logic [4:0] id_rs, id_rt, ex_rd;
   logic       id_use_rt, id_halt, ex_memread, ex_branch_taken, mem_busy, go;
   logic       pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, exmem_clr, memwb_en, memwb_clr;
   logic       halted;
   logic [31:0] stall_cnt, flush_cnt;
   logic [8:0]  dut_vec;

   int errors = 0;
   int checks = 0;

   // Model: mode 0=running, 1=draining, 2=halted.
   int          m_mode = 0;
   int          m_drain_left = 0;
   logic [31:0] m_stall = 0;
   logic [31:0] m_flush = 0;

   pipe_hazard_ctrl #(.REG_AW(5), .DRAIN_CYCLES(DRAIN_N), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rt(id_use_rt), .id_halt(id_halt),
      .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
      .mem_busy(mem_busy), .go(go),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_clr(ifid_clr),
      .idex_en(idex_en), .idex_clr(idex_clr),
      .exmem_en(exmem_en), .exmem_clr(exmem_clr),
      .memwb_en(memwb_en), .memwb_clr(memwb_clr),
      .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   assign dut_vec = {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, exmem_clr, memwb_en, memwb_clr};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic bit hazard();
      return ex_memread && (ex_rd != 0) &&
             ((ex_rd == id_rs) || (id_use_rt && (ex_rd == id_rt)));
   endfunction

   function automatic logic [8:0] model_vec();
      if (rst)               return V_RESET;
      if (m_mode == 2)       return V_FROZEN;
      if (mem_busy)          return V_FROZEN;
      if (m_mode == 1)       return V_DRAIN;
      if (ex_branch_taken)   return V_BRANCH;
      if (hazard())          return V_STALL;
      return V_NORMAL;
   endfunction

   task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Compare against the model, then advance DUT and model by one edge.
   task automatic step();
      lit("model_ctl",   {23'd0, dut_vec}, {23'd0, model_vec()});
      lit("model_halt",  {31'd0, halted}, {31'd0, (m_mode == 2) && !rst});
      lit("model_stall", stall_cnt, m_stall);
      lit("model_flush", flush_cnt, m_flush);
      @(posedge clk);
      if (rst) begin
         m_mode = 0; m_drain_left = 0; m_stall = 0; m_flush = 0;
      end else if (m_mode == 0) begin
         if (!mem_busy && ex_branch_taken) begin
            if (PERF) m_flush = m_flush + 1;
         end else if (!mem_busy && hazard()) begin
            if (PERF) m_stall = m_stall + 1;
         end
         if (!mem_busy && !ex_branch_taken && id_halt) begin
            m_mode = 1; m_drain_left = DRAIN_N;
         end
      end else if (m_mode == 1) begin
         if (!mem_busy) begin
            m_drain_left--;
            if (m_drain_left == 0) m_mode = 2;
         end
      end else if (go) begin
         m_mode = 0;
      end
      @(negedge clk);
   endtask

   task automatic idle();
      rst = 0; id_rs = 0; id_rt = 0; ex_rd = 0; id_use_rt = 0; id_halt = 0;
      ex_memread = 0; ex_branch_taken = 0; mem_busy = 0; go = 0;
   endtask

   initial begin
      idle();
      rst = 1;
      @(posedge clk);
      @(negedge clk);

      // Reset held two cycles.
      for (int i = 0; i < 2; i++) begin
         #1;
         lit("reset_ctl", {23'd0, dut_vec}, {23'd0, V_RESET});
         lit("reset_halted", {31'd0, halted}, 32'd0);
         step();
      end
      lit("reset_stall", stall_cnt, 32'd0);
      lit("reset_flush", flush_cnt, 32'd0);
      idle(); #1;
      lit("post_reset_ctl", {23'd0, dut_vec}, {23'd0, V_NORMAL});
      step();

      // Load-use on rs: one stall cycle, then normal.
      ex_memread = 1; ex_rd = 8; id_rs = 8; #1;
      lit("lu_stall", {23'd0, dut_vec}, {23'd0, V_STALL});
      step();
      ex_memread = 0; #1;
      lit("lu_release", {23'd0, dut_vec}, {23'd0, V_NORMAL});
      lit("lu_stall_cnt", stall_cnt, PERF ? 32'd1 : 32'd0);
      step();

      // Load-use on rt only counts when rt is read.
      idle(); ex_memread = 1; ex_rd = 5; id_rt = 5; #1;
      lit("lu_rt_unused", {23'd0, dut_vec}, {23'd0, V_NORMAL});
      id_use_rt = 1; #1;
      lit("lu_rt_used", {23'd0, dut_vec}, {23'd0, V_STALL});
      step();

      // A load into r0 is never a hazard.
      idle(); ex_memread = 1; ex_rd = 0; id_rs = 0; id_rt = 0; id_use_rt = 1; #1;
      lit("lu_r0", {23'd0, dut_vec}, {23'd0, V_NORMAL});
      step();

      // Branch together with a hazard: branch wins.
      idle(); ex_memread = 1; ex_rd = 8; id_rs = 8; ex_branch_taken = 1; #1;
      lit("br_lu_ctl", {23'd0, dut_vec}, {23'd0, V_BRANCH});
      step();
      idle(); #1;
      lit("br_flush_cnt", flush_cnt, PERF ? 32'd1 : 32'd0);
      lit("br_stall_cnt", stall_cnt, PERF ? 32'd2 : 32'd0);

      // Freeze over a pending hazard, stall fires on the first free cycle.
      ex_memread = 1; ex_rd = 9; id_rs = 9; mem_busy = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         lit("freeze_ctl", {23'd0, dut_vec}, {23'd0, V_FROZEN});
         step();
      end
      mem_busy = 0; #1;
      lit("freeze_then_stall", {23'd0, dut_vec}, {23'd0, V_STALL});
      step();
      idle(); #1;
      lit("freeze_stall_cnt", stall_cnt, PERF ? 32'd3 : 32'd0);

      // Halt behind a taken branch is ignored.
      id_halt = 1; ex_branch_taken = 1; #1;
      step();
      idle(); #1;
      lit("halt_squashed", {23'd0, dut_vec}, {23'd0, V_NORMAL});
      step();

      // Halt with one frozen cycle inside the drain: four drain cycles.
      id_halt = 1; #1;
      step();
      idle();
      for (int i = 0; i < 4; i++) begin
         mem_busy = (i == 1); #1;
         lit("drain_pc_en", {31'd0, pc_en}, 32'd0);
         lit("drain_ctl", {23'd0, dut_vec}, {23'd0, (i == 1) ? V_FROZEN : V_DRAIN});
         lit("drain_halted", {31'd0, halted}, 32'd0);
         step();
      end
      idle(); #1;
      lit("halted_flag", {31'd0, halted}, 32'd1);
      lit("halted_ctl", {23'd0, dut_vec}, {23'd0, V_FROZEN});
      step();
      go = 1; #1;
      step();
      idle(); #1;
      lit("go_resume", {23'd0, dut_vec}, {23'd0, V_NORMAL});
      lit("go_halted", {31'd0, halted}, 32'd0);
      step();

      // Halt again, then reset while halted.
      id_halt = 1; #1;
      step();
      idle();
      for (int i = 0; i < DRAIN_N; i++) begin
         #1;
         step();
      end
      #1;
      lit("halted_again", {31'd0, halted}, 32'd1);
      rst = 1; #1;
      lit("rst_in_halted_ctl", {23'd0, dut_vec}, {23'd0, V_RESET});
      step();
      idle(); #1;
      lit("rst_in_halted_flag", {31'd0, halted}, 32'd0);
      lit("rst_in_halted_run", {23'd0, dut_vec}, {23'd0, V_NORMAL});
      lit("rst_clears_stall", stall_cnt, 32'd0);
      step();

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         rst             = ($urandom_range(0, 99) < 2);
         id_rs           = 5'($urandom_range(0, 3));
         id_rt           = 5'($urandom_range(0, 3));
         ex_rd           = 5'($urandom_range(0, 3));
         id_use_rt       = 1'($urandom_range(0, 1));
         ex_memread      = ($urandom_range(0, 99) < 50);
         ex_branch_taken = ($urandom_range(0, 99) < 20);
         mem_busy        = ($urandom_range(0, 99) < 20);
         id_halt         = ($urandom_range(0, 99) < 6);
         go              = ($urandom_range(0, 99) < 25);
         #1;
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Control side of the pipeline-register interface: drives the en/clr pins of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers, plus the PC enable.
- Detects load-use hazards, flushes on taken branches, freezes the pipeline while memory is busy, and drains/halts on a decoded halt (syscall).
- Sits in the CPU top level beside the stage registers, which sample en/clr on the posedge of clk.

Parameters:
- REG_AW, 5, register-address width.
- DRAIN_CYCLES, 3, non-frozen cycles spent in DRAIN before HALTED; legal range 1..15.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  system clock; all state changes on its posedge.
- rst  input  1  synchronous reset, active-high.
- id_rs  input  REG_AW  rs field of the instruction in ID.
- id_rt  input  REG_AW  rt field of the instruction in ID.
- id_use_rt  input  1  1 when the ID instruction reads rt.
- id_halt  input  1  the ID instruction is a halt.
- ex_rd  input  REG_AW  destination register of the instruction in EX.
- ex_memread  input  1  the EX instruction is a load.
- ex_branch_taken  input  1  branch/jump resolved taken in EX.
- mem_busy  input  1  data memory is not ready this cycle.
- go  input  1  resume pulse; only meaningful in HALTED.
- pc_en  output  1  PC register enable.
- ifid_en, ifid_clr  output  1 each  IF/ID register controls.
- idex_en, idex_clr  output  1 each  ID/EX register controls.
- exmem_en, exmem_clr  output  1 each  EX/MEM register controls.
- memwb_en, memwb_clr  output  1 each  MEM/WB register controls.
- halted  output  1  core halted.
- stall_cnt  output  CNT_W  load-use stall cycles counted.
- flush_cnt  output  CNT_W  branch flush cycles counted.

Behaviour:
- Reset:
  - rst=1 forces state=RUN, drain counter=0, halted=0, stall_cnt=0, flush_cnt=0.
  - While rst=1: every *_clr=1 and every *_en=0 (including pc_en), so all stage registers clear on the same edge.
- All control outputs are combinational from the current state and inputs, so the stage registers act on them at the same edge. State, drain counter and perf counters are registered.
- FSM states:
  - RUN to DRAIN: on id_halt=1 when mem_busy=0 and ex_branch_taken=0 (a halt sitting behind a taken branch is flushed, so it is ignored). The counter loads 0.
  - DRAIN to HALTED: after DRAIN_CYCLES cycles with mem_busy=0. Frozen cycles do not count.
  - HALTED to RUN: on go=1. go is ignored in RUN and DRAIN.
- Hazard detection: load_use = ex_memread & (ex_rd != 0) & ((ex_rd == id_rs) | (id_use_rt & ex_rd == id_rt)).
- Output priority in RUN, highest first:
  1. mem_busy=1: all en=0, all clr=0 (freeze). No counters advance.
  2. ex_branch_taken=1: ifid_clr=1, idex_clr=1, all en=1. flush_cnt += 1.
  3. load_use=1: pc_en=0, ifid_en=0, idex_clr=1; the other stages enabled. stall_cnt += 1.
  4. Otherwise: all en=1, all clr=0.
- Branch and load-use in the same cycle: branch wins, since the ID instruction is squashed anyway. Only flush_cnt increments.
- A load-use stall lasts exactly 1 cycle. The dependent instruction advances the next cycle with ex_memread now deasserted for that pair.
- DRAIN:
  - pc_en=0; ifid_clr=1 (NOP injection); idex, exmem, memwb enabled.
  - mem_busy=1 still freezes all stages.
  - ex_branch_taken and load_use are ignored.
- HALTED: all en=0, all clr=0, halted=1.
- rst in DRAIN or HALTED returns to RUN immediately, with the reset outputs above.
- Counters wrap modulo 2^CNT_W.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined: stall_cnt and flush_cnt count as described above.
- Undefined: the counter flops are not built; stall_cnt and flush_cnt are tied to 0. The ports remain so the top-level wiring does not change.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state encoding: RUN=2'd0, DRAIN=2'd1, HALTED=2'd2.
  - default constants REG_AW and DRAIN_CYCLES.
  - a packed struct bundling one stage's {en, clr} pair.
- Sub-module: pipe_load_use_detect, purely combinational, computing load_use from id_rs, id_rt, id_use_rt, ex_rd and ex_memread. It is reusable by the forwarding unit.

Test Plan:
- Reset: hold rst=1 for 2 cycles -> every *_clr=1, every *_en=0, halted=0, both counters 0. After release with no inputs active -> all en=1, all clr=0.
- Load-use: ex_memread=1, ex_rd=8, id_rs=8 -> exactly 1 cycle of pc_en=0, ifid_en=0, idex_clr=1, then normal; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- Branch plus load-use together: ex_branch_taken=1 with the hazard present -> ifid_clr=1, idex_clr=1, pc_en=1; flush_cnt=1, stall_cnt unchanged.
- Freeze: mem_busy=1 for 4 cycles during a load-use hazard -> all en=0 and clr=0 for those 4 cycles; the stall fires on the first non-busy cycle.
- Halt: id_halt=1 with DRAIN_CYCLES=3 and mem_busy=1 asserted once during drain -> 4 cycles in DRAIN with pc_en=0, then halted=1 and all en=0. A go pulse returns to RUN the next cycle.
- rst asserted in HALTED -> state RUN and halted=0 after the edge. With PIPE_PERF_CNT_EN undefined, the counters stay 0 through all of the above.
